// File: rtl/riscv_pkg.sv
// Shared constants and types for the decode-stage operand logic.
//   XLEN       datapath width
//   CTRL_W     width of the opaque decoded control bundle
//   REG_X0     index of the hard-wired zero register
//   fwd_sel_e  which source an operand was resolved from
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_RF
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bus between the decode logic / pipeline neighbours and the ID/EX operand stage.
//   master : decoder, register file and later stages (drive ID, RF data, forwarding, flush)
//   slave  : the operand stage (drives RF addresses, stall, ID/EX register, stall counter)
interface id_ex_operand_stage_if
    import riscv_pkg::*;
();

    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [4:0]        id_rd;
    logic              id_rd_wen;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;

    logic [4:0]        rf_rs1;
    logic [4:0]        rf_rs2;
    logic [XLEN-1:0]   rf_rs1_v;
    logic [XLEN-1:0]   rf_rs2_v;

    logic              ex_fwd_vld;
    logic [XLEN-1:0]   ex_fwd_val;
    logic              mem_wen;
    logic [4:0]        mem_rd;
    logic              mem_fwd_vld;
    logic [XLEN-1:0]   mem_fwd_val;
    logic              wb_wen;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_rd_v;

    logic              ex_flush;
    logic              id_stall;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_rs1_v;
    logic [XLEN-1:0]   ex_rs2_v;
    logic [4:0]        ex_rd;
    logic              ex_rd_wen;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       stall_cnt;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_rd_wen, id_imm, id_ctrl,
               rf_rs1_v, rf_rs2_v,
               ex_fwd_vld, ex_fwd_val, mem_wen, mem_rd, mem_fwd_vld, mem_fwd_val,
               wb_wen, wb_rd, wb_rd_v, ex_flush,
        input  rf_rs1, rf_rs2, id_stall,
               ex_valid, ex_pc, ex_imm, ex_rs1_v, ex_rs2_v, ex_rd, ex_rd_wen,
               ex_ctrl, stall_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_rd_wen, id_imm, id_ctrl,
               rf_rs1_v, rf_rs2_v,
               ex_fwd_vld, ex_fwd_val, mem_wen, mem_rd, mem_fwd_vld, mem_fwd_val,
               wb_wen, wb_rd, wb_rd_v, ex_flush,
        output rf_rs1, rf_rs2, id_stall,
               ex_valid, ex_pc, ex_imm, ex_rs1_v, ex_rs2_v, ex_rd, ex_rd_wen,
               ex_ctrl, stall_cnt
    );

endinterface

// File: rtl/operand_bypass.sv
// Resolves one source operand: picks the youngest in-flight producer of the
// register, else the register-file value.
//   idx/rf_v            source index and register-file data
//   ex_* / mem_* / wb_* producer state of the three later stages
//   val                 resolved operand
//   sel                 source the operand came from
//   hazard              selected producer has not produced its final value yet
module operand_bypass
    import riscv_pkg::*;
(
    input  logic [4:0]      idx,
    input  logic [XLEN-1:0] rf_v,
    input  logic            ex_valid,
    input  logic            ex_rd_wen,
    input  logic [4:0]      ex_rd,
    input  logic            ex_fwd_vld,
    input  logic [XLEN-1:0] ex_fwd_val,
    input  logic            mem_wen,
    input  logic [4:0]      mem_rd,
    input  logic            mem_fwd_vld,
    input  logic [XLEN-1:0] mem_fwd_val,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_rd_v,
    output logic [XLEN-1:0] val,
    output fwd_sel_e        sel,
    output logic            hazard
);

    // EX wins even when its value is not final: an older MEM/WB value for
    // the same register would be stale, so the stage must wait instead.
    always_comb begin
        sel    = FWD_RF;
        val    = rf_v;
        hazard = 1'b0;
        if (idx == REG_X0) begin
            sel = FWD_ZERO;
            val = '0;
        end else if (ex_valid && ex_rd_wen && (ex_rd == idx)) begin
            sel    = FWD_EX;
            val    = ex_fwd_val;
            hazard = ~ex_fwd_vld;
        end else if (mem_wen && (mem_rd == idx)) begin
            sel    = FWD_MEM;
            val    = mem_fwd_val;
            hazard = ~mem_fwd_vld;
        end else if (wb_wen && (wb_rd == idx)) begin
            // register file only absorbs the WB write at the next edge
            sel = FWD_WB;
            val = wb_rd_v;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Decode-stage operand resolution, load-use stall and the ID/EX pipeline register.
//   clk   core clock
//   rst   synchronous active-high reset
//   bus   slave side of id_ex_operand_stage_if (ID inputs, RF port, forwarding,
//         flush, stall, ID/EX register outputs, stall counter)
module id_ex_operand_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    id_ex_operand_stage_if.slave  bus
);

    logic              ex_valid_q;
    logic [XLEN-1:0]   ex_pc_q;
    logic [XLEN-1:0]   ex_imm_q;
    logic [XLEN-1:0]   ex_rs1_v_q;
    logic [XLEN-1:0]   ex_rs2_v_q;
    logic [4:0]        ex_rd_q;
    logic              ex_rd_wen_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [31:0]       stall_cnt_q;

    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    fwd_sel_e          rs1_sel;
    fwd_sel_e          rs2_sel;
    logic              rs1_haz;
    logic              rs2_haz;
    logic              rs1_wait;
    logic              rs2_wait;
    logic              stall;

    assign bus.rf_rs1 = bus.id_rs1;
    assign bus.rf_rs2 = bus.id_rs2;

    operand_bypass u_byp_rs1 (
        .idx         (bus.id_rs1),
        .rf_v        (bus.rf_rs1_v),
        .ex_valid    (ex_valid_q),
        .ex_rd_wen   (ex_rd_wen_q),
        .ex_rd       (ex_rd_q),
        .ex_fwd_vld  (bus.ex_fwd_vld),
        .ex_fwd_val  (bus.ex_fwd_val),
        .mem_wen     (bus.mem_wen),
        .mem_rd      (bus.mem_rd),
        .mem_fwd_vld (bus.mem_fwd_vld),
        .mem_fwd_val (bus.mem_fwd_val),
        .wb_wen      (bus.wb_wen),
        .wb_rd       (bus.wb_rd),
        .wb_rd_v     (bus.wb_rd_v),
        .val         (rs1_val),
        .sel         (rs1_sel),
        .hazard      (rs1_haz)
    );

    operand_bypass u_byp_rs2 (
        .idx         (bus.id_rs2),
        .rf_v        (bus.rf_rs2_v),
        .ex_valid    (ex_valid_q),
        .ex_rd_wen   (ex_rd_wen_q),
        .ex_rd       (ex_rd_q),
        .ex_fwd_vld  (bus.ex_fwd_vld),
        .ex_fwd_val  (bus.ex_fwd_val),
        .mem_wen     (bus.mem_wen),
        .mem_rd      (bus.mem_rd),
        .mem_fwd_vld (bus.mem_fwd_vld),
        .mem_fwd_val (bus.mem_fwd_val),
        .wb_wen      (bus.wb_wen),
        .wb_rd       (bus.wb_rd),
        .wb_rd_v     (bus.wb_rd_v),
        .val         (rs2_val),
        .sel         (rs2_sel),
        .hazard      (rs2_haz)
    );

    // Only EX and MEM producers can be pending; operands that are not read never wait.
    assign rs1_wait = bus.id_use_rs1 && rs1_haz && (rs1_sel inside {FWD_EX, FWD_MEM});
    assign rs2_wait = bus.id_use_rs2 && rs2_haz && (rs2_sel inside {FWD_EX, FWD_MEM});

    // A redirect kills the ID instruction, so there is nothing left to wait for.
    assign stall        = ~rst && bus.id_valid && (rs1_wait || rs2_wait) && ~bus.ex_flush;
    assign bus.id_stall = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_pc_q     <= '0;
            ex_imm_q    <= '0;
            ex_rs1_v_q  <= '0;
            ex_rs2_v_q  <= '0;
            ex_rd_q     <= '0;
            ex_rd_wen_q <= 1'b0;
            ex_ctrl_q   <= '0;
            stall_cnt_q <= '0;
        end else if (bus.ex_flush) begin
            ex_valid_q  <= 1'b0;
            ex_rd_wen_q <= 1'b0;
        end else if (stall) begin
            ex_valid_q  <= 1'b0;
            ex_rd_wen_q <= 1'b0;
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            ex_valid_q  <= bus.id_valid;
            ex_pc_q     <= bus.id_pc;
            ex_imm_q    <= bus.id_imm;
            ex_rs1_v_q  <= rs1_val;
            ex_rs2_v_q  <= rs2_val;
            ex_rd_q     <= bus.id_rd;
            ex_rd_wen_q <= bus.id_valid && bus.id_rd_wen;
            ex_ctrl_q   <= bus.id_ctrl;
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_pc     = ex_pc_q;
    assign bus.ex_imm    = ex_imm_q;
    assign bus.ex_rs1_v  = ex_rs1_v_q;
    assign bus.ex_rs2_v  = ex_rs2_v_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.ex_rd_wen = ex_rd_wen_q;
    assign bus.ex_ctrl   = ex_ctrl_q;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed and randomized checks of id_ex_operand_stage against a reference model
// that tracks the instruction sitting in EX and resolves operands by scanning the
// in-flight producers youngest-first.
module tb_id_ex_operand_stage;

    logic clk;
    logic rst;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf_mem [32];
    assign bus.rf_rs1_v = rf_mem[bus.rf_rs1];
    assign bus.rf_rs2_v = rf_mem[bus.rf_rs2];

    int n_vec  = 0;
    int n_miss = 0;

    // model of the instruction held in EX
    logic        m_valid;
    logic [31:0] m_pc, m_imm, m_rs1_v, m_rs2_v;
    logic [4:0]  m_rd;
    logic        m_rd_wen;
    logic [15:0] m_ctrl;
    logic [31:0] m_cnt;
    logic        m_all;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Youngest producer of idx wins; x0 is always zero; WB is always final.
    task automatic resolve(input logic [4:0] idx, input logic used,
                           output logic [31:0] v, output logic wait_);
        logic [4:0]  p_rd  [3];
        logic        p_on  [3];
        logic [31:0] p_val [3];
        logic        p_rdy [3];
        bit found;
        p_on[0] = m_valid && m_rd_wen; p_rd[0] = m_rd;       p_val[0] = bus.ex_fwd_val;  p_rdy[0] = bus.ex_fwd_vld;
        p_on[1] = bus.mem_wen;         p_rd[1] = bus.mem_rd; p_val[1] = bus.mem_fwd_val; p_rdy[1] = bus.mem_fwd_vld;
        p_on[2] = bus.wb_wen;          p_rd[2] = bus.wb_rd;  p_val[2] = bus.wb_rd_v;     p_rdy[2] = 1'b1;
        v = rf_mem[idx];
        wait_ = 1'b0;
        found = 0;
        if (idx == 5'd0) begin
            v = 32'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!found && p_on[i] && p_rd[i] == idx) begin
                    found = 1;
                    v = p_val[i];
                    wait_ = used && !p_rdy[i];
                end
            end
        end
    endtask

    task automatic cycle();
        logic [31:0] v1, v2;
        logic w1, w2, st;
        #1;
        resolve(bus.id_rs1, bus.id_use_rs1, v1, w1);
        resolve(bus.id_rs2, bus.id_use_rs2, v2, w2);
        st = !rst && bus.id_valid && (w1 || w2) && !bus.ex_flush;
        chk("id_stall", {31'd0, bus.id_stall}, {31'd0, st});
        chk("rf_addr", {22'd0, bus.rf_rs1, bus.rf_rs2}, {22'd0, bus.id_rs1, bus.id_rs2});
        m_all = rst;
        if (rst) begin
            m_valid = 0; m_pc = 0; m_imm = 0; m_rs1_v = 0; m_rs2_v = 0;
            m_rd = 0; m_rd_wen = 0; m_ctrl = 0; m_cnt = 0;
        end else if (bus.ex_flush || st) begin
            m_valid  = 0;
            m_rd_wen = 0;
            if (!bus.ex_flush) m_cnt = m_cnt + 32'd1;
        end else begin
            m_valid  = bus.id_valid;
            m_pc     = bus.id_pc;
            m_imm    = bus.id_imm;
            m_rs1_v  = v1;
            m_rs2_v  = v2;
            m_rd     = bus.id_rd;
            m_rd_wen = bus.id_valid && bus.id_rd_wen;
            m_ctrl   = bus.id_ctrl;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
        chk("ex_rd_wen", {31'd0, bus.ex_rd_wen}, {31'd0, m_rd_wen});
        chk("stall_cnt", bus.stall_cnt, m_cnt);
        if (m_valid || m_all) begin
            chk("ex_pc", bus.ex_pc, m_pc);
            chk("ex_imm", bus.ex_imm, m_imm);
            chk("ex_rs1_v", bus.ex_rs1_v, m_rs1_v);
            chk("ex_rs2_v", bus.ex_rs2_v, m_rs2_v);
            chk("ex_rd", {27'd0, bus.ex_rd}, {27'd0, m_rd});
            chk("ex_ctrl", {16'd0, bus.ex_ctrl}, {16'd0, m_ctrl});
        end
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_rd = 0; bus.id_rd_wen = 0;
        bus.id_imm = 0; bus.id_ctrl = 0;
        bus.ex_fwd_vld = 1; bus.ex_fwd_val = 0;
        bus.mem_wen = 0; bus.mem_rd = 0; bus.mem_fwd_vld = 1; bus.mem_fwd_val = 0;
        bus.wb_wen = 0; bus.wb_rd = 0; bus.wb_rd_v = 0; bus.ex_flush = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic rd_wen);
        bus.id_valid = 1; bus.id_pc = 32'h1000 + {27'd0, rd, 2'd0};
        bus.id_rs1 = rs1; bus.id_use_rs1 = u1; bus.id_rs2 = rs2; bus.id_use_rs2 = u2;
        bus.id_rd = rd; bus.id_rd_wen = rd_wen;
        bus.id_imm = $urandom; bus.id_ctrl = 16'($urandom);
    endtask

    logic [31:0] cnt0;

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 0;
        idle();
        rst = 1;
        cycle();
        cycle();
        chk("reset_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("reset_stall_cnt", bus.stall_cnt, 32'd0);
        rst = 0;

        // plain register-file read
        rf_mem[3] = 32'h11;
        issue(5'd3, 1, 5'd0, 0, 5'd0, 0);
        cycle();
        chk("t1_rs1", bus.ex_rs1_v, 32'h11);
        chk("t1_valid", {31'd0, bus.ex_valid}, 32'd1);

        // EX beats MEM for the same register
        idle(); issue(5'd0, 0, 5'd0, 0, 5'd5, 1);
        cycle();
        idle(); issue(5'd5, 1, 5'd0, 0, 5'd1, 0);
        bus.ex_fwd_vld = 1; bus.ex_fwd_val = 32'hAA;
        bus.mem_wen = 1; bus.mem_rd = 5; bus.mem_fwd_val = 32'hBB;
        cycle();
        chk("t2_rs1", bus.ex_rs1_v, 32'hAA);

        // load-use: two stalls then WB forwarding
        idle(); issue(5'd0, 0, 5'd0, 0, 5'd7, 1);
        cycle();
        cnt0 = bus.stall_cnt;
        idle(); issue(5'd1, 1, 5'd7, 1, 5'd2, 0);
        bus.ex_fwd_vld = 0;
        cycle();
        chk("t3_bubble1", {31'd0, bus.ex_valid}, 32'd0);
        bus.ex_fwd_vld = 1;
        bus.mem_wen = 1; bus.mem_rd = 7; bus.mem_fwd_vld = 0;
        cycle();
        chk("t3_bubble2", {31'd0, bus.ex_valid}, 32'd0);
        bus.mem_wen = 0; bus.mem_fwd_vld = 1;
        bus.wb_wen = 1; bus.wb_rd = 7; bus.wb_rd_v = 32'h42;
        cycle();
        chk("t3_rs2", bus.ex_rs2_v, 32'h42);
        chk("t3_cnt", bus.stall_cnt, cnt0 + 32'd2);

        // WB bypass while register file is stale
        rf_mem[9] = 0;
        idle(); issue(5'd9, 1, 5'd0, 0, 5'd3, 0);
        bus.wb_wen = 1; bus.wb_rd = 9; bus.wb_rd_v = 32'h77;
        cycle();
        chk("t4_rs1", bus.ex_rs1_v, 32'h77);

        // x0 never forwarded; unused source never stalls
        idle(); issue(5'd0, 0, 5'd0, 0, 5'd0, 1);
        cycle();
        idle(); issue(5'd0, 1, 5'd0, 1, 5'd6, 0);
        bus.ex_fwd_val = 32'h5;
        cycle();
        chk("t5_x0_rs1", bus.ex_rs1_v, 32'd0);
        chk("t5_x0_rs2", bus.ex_rs2_v, 32'd0);
        idle(); issue(5'd0, 0, 5'd0, 0, 5'd4, 1);
        cycle();
        idle(); issue(5'd4, 0, 5'd0, 0, 5'd6, 0);
        bus.ex_fwd_vld = 0;
        cycle();
        chk("t5_unused", {31'd0, bus.ex_valid}, 32'd1);

        // flush overrides stall
        idle(); issue(5'd0, 0, 5'd0, 0, 5'd8, 1);
        cycle();
        cnt0 = bus.stall_cnt;
        idle(); issue(5'd8, 1, 5'd0, 0, 5'd2, 0);
        bus.ex_fwd_vld = 0; bus.ex_flush = 1;
        cycle();
        chk("t6_flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("t6_flush_cnt", bus.stall_cnt, cnt0);

        // reset in the middle of a stall
        idle(); issue(5'd0, 0, 5'd0, 0, 5'd8, 1);
        cycle();
        idle(); issue(5'd8, 1, 5'd0, 0, 5'd2, 1);
        bus.ex_fwd_vld = 0;
        cycle();
        rst = 1;
        cycle();
        chk("t6_rst_cnt", bus.stall_cnt, 32'd0);
        chk("t6_rst_rs1", bus.ex_rs1_v, 32'd0);
        rst = 0;

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            bus.id_valid    = $urandom_range(0, 3) != 0;
            bus.id_pc       = $urandom;
            bus.id_imm      = $urandom;
            bus.id_ctrl     = 16'($urandom);
            bus.id_rs1      = 5'($urandom_range(0, 7));
            bus.id_rs2      = 5'($urandom_range(0, 7));
            bus.id_use_rs1  = $urandom_range(0, 3) != 0;
            bus.id_use_rs2  = $urandom_range(0, 1) != 0;
            bus.id_rd       = 5'($urandom_range(0, 7));
            bus.id_rd_wen   = $urandom_range(0, 2) != 0;
            bus.ex_fwd_vld  = $urandom_range(0, 2) != 0;
            bus.ex_fwd_val  = $urandom;
            bus.mem_wen     = $urandom_range(0, 1) != 0;
            bus.mem_rd      = 5'($urandom_range(0, 7));
            bus.mem_fwd_vld = $urandom_range(0, 2) != 0;
            bus.mem_fwd_val = $urandom;
            bus.wb_wen      = $urandom_range(0, 1) != 0;
            bus.wb_rd       = 5'($urandom_range(0, 7));
            bus.wb_rd_v     = $urandom;
            bus.ex_flush    = $urandom_range(0, 15) == 0;
            rst             = $urandom_range(0, 59) == 0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
